// File: rtl/aes_ctr_scheduler_if.sv
// aes_ctr_scheduler_if
//   Bundles everything the counter-mode scheduler exchanges with the outside
//   world except clock and reset.
//   slave  : scheduler view (config/control in, AES issue out, AES result in,
//            keystream stream out).
//   master : environment view (mirror of slave).
//   Signals:
//     cfg_key/cfg_nonce/cfg_ctr0/cfg_nblk - job configuration, sampled on start
//     start/abort                         - job control
//     busy/done                           - job status
//     aes_kin/aes_din/aes_drdy            - block issue towards the AES core
//     aes_dout/aes_dvld                   - ciphertext back from the AES core
//     out_data/out_valid/out_ready        - keystream ready/valid stream
interface aes_ctr_scheduler_if #(
  parameter int CTR_W = 32
);
  logic [127:0]       cfg_key;
  logic [127-CTR_W:0] cfg_nonce;
  logic [CTR_W-1:0]   cfg_ctr0;
  logic [CTR_W-1:0]   cfg_nblk;
  logic               start;
  logic               abort;
  logic               busy;
  logic               done;
  logic [127:0]       aes_kin;
  logic [127:0]       aes_din;
  logic               aes_drdy;
  logic [127:0]       aes_dout;
  logic               aes_dvld;
  logic [127:0]       out_data;
  logic               out_valid;
  logic               out_ready;

  modport slave (
    input  cfg_key, cfg_nonce, cfg_ctr0, cfg_nblk, start, abort,
    input  aes_dout, aes_dvld, out_ready,
    output busy, done, aes_kin, aes_din, aes_drdy, out_data, out_valid
  );

  modport master (
    output cfg_key, cfg_nonce, cfg_ctr0, cfg_nblk, start, abort,
    output aes_dout, aes_dvld, out_ready,
    input  busy, done, aes_kin, aes_din, aes_drdy, out_data, out_valid
  );
endinterface

// File: rtl/aes_ctr_scheduler.sv
// aes_ctr_scheduler
//   Drives a pipelined AES-128 core in counter mode and buffers its results
//   in a first-word-fall-through FIFO presented as a ready/valid stream.
//   Issue is credit based (in-flight blocks + buffered words never exceed
//   FIFO_DEPTH), so core results are never dropped under backpressure.
//   Ports:
//     CLK  - clock
//     RSTn - asynchronous active-low reset
//     bus  - aes_ctr_scheduler_if.slave (config, control, status, AES core
//            issue/result, keystream output stream)
module aes_ctr_scheduler #(
  parameter int FIFO_DEPTH = 32,
  parameter int CTR_W      = 32
) (
  input logic                CLK,
  input logic                RSTn,
  aes_ctr_scheduler_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int NW = 128 - CTR_W;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FLUSH} state_t;

  state_t           state_q, state_d;
  logic [127:0]     key_q, key_d;
  logic [NW-1:0]    nonce_q, nonce_d;
  logic [CTR_W-1:0] ctr_q, ctr_d;
  logic [CTR_W-1:0] rem_q, rem_d;
  logic [127:0]     din_q, din_d;
  logic             drdy_q, drdy_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CW-1:0]    infl_q, infl_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [127:0]     mem_q [FIFO_DEPTH];

  logic             issue, flush;
  logic             out_valid_w, fifo_rd, fifo_wr, dvld_ok, credit_ok;
  logic [CW:0]      used;

  // Credit is taken from registered counts; a read in the same cycle is not
  // credited until the next cycle, which keeps the FIFO strictly safe.
  assign used        = {1'b0, infl_q} + {1'b0, cnt_q};
  assign credit_ok   = used < DEPTH_C;
  assign out_valid_w = cnt_q != '0;
  assign fifo_rd     = out_valid_w && bus.out_ready;
  // Results with nothing in flight (e.g. stale after reset) are discarded.
  assign dvld_ok     = bus.aes_dvld && (infl_q != '0);
  assign fifo_wr     = dvld_ok && ((state_q == ISSUE) || (state_q == DRAIN));

  // Next-state and job datapath. The first block is issued straight from
  // IDLE so that aes_drdy rises in the cycle right after the start cycle;
  // rem_q therefore counts blocks still to issue after the current one.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    nonce_d = nonce_q;
    ctr_d   = ctr_q;
    rem_d   = rem_q;
    din_d   = din_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    issue   = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          key_d   = bus.cfg_key;
          nonce_d = bus.cfg_nonce;
          busy_d  = 1'b1;
          if (bus.cfg_nblk == '0) begin
            ctr_d   = bus.cfg_ctr0;
            rem_d   = '0;
            state_d = DRAIN;
          end else begin
            issue   = 1'b1;
            din_d   = {bus.cfg_nonce, bus.cfg_ctr0};
            ctr_d   = bus.cfg_ctr0 + 1'b1;
            rem_d   = bus.cfg_nblk - 1'b1;
            state_d = (bus.cfg_nblk == CTR_W'(1)) ? DRAIN : ISSUE;
          end
        end
      end
      ISSUE: begin
        if (bus.abort) begin
          flush   = 1'b1;
          state_d = FLUSH;
        end else if ((rem_q != '0) && credit_ok) begin
          issue = 1'b1;
          din_d = {nonce_q, ctr_q};
          ctr_d = ctr_q + 1'b1;
          rem_d = rem_q - 1'b1;
          if (rem_q == CTR_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.abort) begin
          flush   = 1'b1;
          state_d = FLUSH;
        end else if ((infl_q == '0) && (cnt_q == '0)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      FLUSH: begin
        if (infl_q == '0) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    drdy_d = issue;
  end

  // In-flight and FIFO bookkeeping.
  always_comb begin
    infl_d = infl_q;
    unique case ({issue, dvld_ok})
      2'b10:   infl_d = infl_q + 1'b1;
      2'b01:   infl_d = infl_q - 1'b1;
      default: infl_d = infl_q;
    endcase
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      wptr_d = wptr_q + AW'(fifo_wr);
      rptr_d = rptr_q + AW'(fifo_rd);
      unique case ({fifo_wr, fifo_rd})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
      key_q   <= '0;
      nonce_q <= '0;
      ctr_q   <= '0;
      rem_q   <= '0;
      din_q   <= '0;
      drdy_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      infl_q  <= '0;
      cnt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      nonce_q <= nonce_d;
      ctr_q   <= ctr_d;
      rem_q   <= rem_d;
      din_q   <= din_d;
      drdy_q  <= drdy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      infl_q  <= infl_d;
      cnt_q   <= cnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  // Storage array carries no reset; out_data is gated to zero when empty.
  always_ff @(posedge CLK) begin
    if (fifo_wr) mem_q[wptr_q] <= bus.aes_dout;
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.aes_kin   = key_q;
  assign bus.aes_din   = din_q;
  assign bus.aes_drdy  = drdy_q;
  assign bus.out_valid = out_valid_w;
  assign bus.out_data  = out_valid_w ? mem_q[rptr_q] : '0;
endmodule

// File: tb/tb_aes_ctr_scheduler.sv
// tb_aes_ctr_scheduler
//   Table-driven jobs plus hand sequences (backpressure, abort, reset) around
//   a behavioural AES-128 core with fixed latency; expected keystream words
//   are queued when blocks are issued and compared as the stream delivers.
module tb_aes_ctr_scheduler;
  localparam int LAT   = 4;
  localparam int DEPTH = 32;

  logic CLK;
  logic RSTn;

  aes_ctr_scheduler_if #(.CTR_W(32)) bus ();

  aes_ctr_scheduler #(.FIFO_DEPTH(DEPTH), .CTR_W(32)) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int iss_cnt = 0;
  int dvld_cnt = 0;
  int pop_cnt = 0;
  int done_cnt = 0;
  bit rdy_rand = 1'b0;
  logic [127:0] exp_q [$];
  logic [127:0] din_q [$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- AES-128 reference ----------------
  logic [7:0] sbox [256];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  task automatic build_sbox();
    for (int v = 0; v < 256; v++) begin
      logic [7:0] x;
      logic [7:0] inv;
      x = 8'(v);
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gmul(inv, x);
      sbox[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc = 8'h01;
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int n = 0; n < 16; n++) s[n] = pt[127-8*n -: 8] ^ w[n/4][31-8*(n%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int n = 0; n < 16; n++) t[n] = sbox[s[n]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int n = 0; n < 16; n++) s[n] ^= w[4*rnd + n/4][31-8*(n%4) -: 8];
    end
    for (int n = 0; n < 16; n++) res[127-8*n -: 8] = s[n];
    return res;
  endfunction

  // ---------------- AES core model (fixed latency, in-order) ----------------
  logic         pv [LAT];
  logic [127:0] pd [LAT];

  initial begin
    for (int i = 0; i < LAT; i++) begin
      pv[i] = 1'b0;
      pd[i] = '0;
    end
    bus.aes_dvld = 1'b0;
    bus.aes_dout = '0;
    forever begin
      @(negedge CLK);
      for (int i = LAT - 1; i > 0; i--) begin
        pv[i] = pv[i-1];
        pd[i] = pd[i-1];
      end
      pv[0] = bus.aes_drdy;
      if (bus.aes_drdy) begin
        pd[0] = aes_enc(bus.aes_kin, bus.aes_din);
        exp_q.push_back(pd[0]);
        din_q.push_back(bus.aes_din);
        iss_cnt++;
      end
      bus.aes_dvld = pv[LAT-1];
      bus.aes_dout = pd[LAT-1];
      if (pv[LAT-1]) dvld_cnt++;
    end
  end

  // ---------------- consumer / monitor ----------------
  initial forever begin
    @(posedge CLK);
    #2;
    if (rdy_rand) bus.out_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    logic         pvld = 1'b0;
    logic         prdy = 1'b0;
    logic [127:0] pdat = '0;
    forever begin
      @(negedge CLK);
      if (bus.done) begin
        done_cnt++;
        chk("busy_low_with_done", bus.busy, 0);
      end
      if (pvld && !prdy && bus.out_valid) chk("hold_data", bus.out_data, pdat);
      if (bus.out_valid && bus.out_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected: got %h expected no word", bus.out_data);
        end else begin
          chk("sb_word", bus.out_data, exp_q.pop_front());
        end
      end
      pvld = bus.out_valid;
      prdy = bus.out_ready;
      pdat = bus.out_data;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- job table ----------------
  typedef struct {
    logic [127:0] key;
    logic [95:0]  nonce;
    logic [31:0]  ctr0;
    logic [31:0]  nblk;
    bit           rnd_rdy;
    bit           exp_drdy_t1;
    int           exp_issues;
    logic [31:0]  exp_last_ctr;
    int           exp_done_max;
  } job_t;

  task automatic start_job(input logic [127:0] key, input logic [95:0] nonce,
                           input logic [31:0] ctr0, input logic [31:0] nblk);
    bus.cfg_key   = key;
    bus.cfg_nonce = nonce;
    bus.cfg_ctr0  = ctr0;
    bus.cfg_nblk  = nblk;
    bus.start     = 1'b1;
  endtask

  task automatic run_job(input job_t j, input string nm);
    int base_iss, base_pop, base_done, cyc;
    bit got_done, saw_valid;
    rdy_rand = j.rnd_rdy;
    @(posedge CLK); #1;
    if (!j.rnd_rdy) bus.out_ready = 1'b1;
    din_q.delete();
    base_iss  = iss_cnt;
    base_pop  = pop_cnt;
    base_done = done_cnt;
    start_job(j.key, j.nonce, j.ctr0, j.nblk);
    @(posedge CLK); #1;
    bus.start = 1'b0;
    chk({nm, "_drdy_T1"}, bus.aes_drdy, j.exp_drdy_t1);
    cyc = 0; got_done = 1'b0; saw_valid = 1'b0;
    while (!got_done && cyc < 3000) begin
      @(negedge CLK);
      cyc++;
      if (bus.out_valid) saw_valid = 1'b1;
      if (bus.done) got_done = 1'b1;
    end
    chk({nm, "_done_seen"}, got_done, 1);
    chk({nm, "_done_latency_ok"}, cyc <= j.exp_done_max, 1);
    repeat (3) @(negedge CLK);
    chk({nm, "_done_pulses"}, done_cnt - base_done, 1);
    chk({nm, "_issues"}, iss_cnt - base_iss, j.exp_issues);
    chk({nm, "_words"}, pop_cnt - base_pop, j.exp_issues);
    chk({nm, "_valid_seen"}, saw_valid, j.exp_issues != 0);
    chk({nm, "_sb_empty"}, exp_q.size(), 0);
    for (int i = 0; i < din_q.size(); i++)
      chk({nm, "_din"}, din_q[i], {j.nonce, j.ctr0 + 32'(i)});
    if (din_q.size() != 0) chk({nm, "_last_ctr"}, din_q[din_q.size()-1][31:0], j.exp_last_ctr);
  endtask

  job_t tbl [6];

  initial begin
    int base_iss, base_pop, base_done, base_dv, cyc, occ, max_occ, n;
    bit flag_drdy, flag_valid, got;

    tbl[0] = '{key:128'h2b7e151628aed2a6abf7158809cf4f3c, nonce:96'h0, ctr0:32'h0, nblk:32'd4,
               rnd_rdy:0, exp_drdy_t1:1, exp_issues:4, exp_last_ctr:32'h3, exp_done_max:16};
    tbl[1] = '{key:128'h000102030405060708090a0b0c0d0e0f, nonce:96'hdeadbeef_cafef00d_12345678,
               ctr0:32'hFFFFFFFE, nblk:32'd4, rnd_rdy:0, exp_drdy_t1:1, exp_issues:4,
               exp_last_ctr:32'h00000001, exp_done_max:16};
    tbl[2] = '{key:128'h11, nonce:96'h5, ctr0:32'h9, nblk:32'd0, rnd_rdy:0, exp_drdy_t1:0,
               exp_issues:0, exp_last_ctr:32'h0, exp_done_max:3};
    tbl[3] = '{key:128'hffeeddccbbaa99887766554433221100, nonce:96'ha5a5, ctr0:32'h1000, nblk:32'd40,
               rnd_rdy:1, exp_drdy_t1:1, exp_issues:40, exp_last_ctr:32'h1027, exp_done_max:3000};
    tbl[4] = '{key:128'h1, nonce:96'h77, ctr0:32'h55, nblk:32'd1, rnd_rdy:0, exp_drdy_t1:1,
               exp_issues:1, exp_last_ctr:32'h55, exp_done_max:16};
    tbl[5] = '{key:128'h2b7e151628aed2a6abf7158809cf4f3c, nonce:96'h3, ctr0:32'h7, nblk:32'd2,
               rnd_rdy:0, exp_drdy_t1:1, exp_issues:2, exp_last_ctr:32'h8, exp_done_max:16};

    RSTn = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.out_ready = 1'b1;
    bus.cfg_key = '0; bus.cfg_nonce = '0; bus.cfg_ctr0 = '0; bus.cfg_nblk = '0;
    build_sbox();
    #2 RSTn = 1'b0;
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_drdy", bus.aes_drdy, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_kin", bus.aes_kin, '0);
    chk("rst_din", bus.aes_din, '0);
    chk("rst_data", bus.out_data, '0);
    repeat (2) @(posedge CLK);
    #1 RSTn = 1'b1;

    for (int i = 0; i < 5; i++) run_job(tbl[i], $sformatf("job%0d", i));

    // Backpressure: consumer stalled, credit must cap the outstanding blocks.
    rdy_rand = 1'b0;
    @(posedge CLK); #1;
    bus.out_ready = 1'b0;
    base_iss = iss_cnt; base_pop = pop_cnt; base_dv = dvld_cnt; base_done = done_cnt;
    start_job(128'h0f0e0d0c0b0a09080706050403020100, 96'h42, 32'h200, 32'd100);
    max_occ = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge CLK); #1;
      bus.start = 1'b0;
      occ = (iss_cnt - base_iss) - (pop_cnt - base_pop);
      if (occ > max_occ) max_occ = occ;
    end
    chk("bp_max_outstanding_le_depth", max_occ <= DEPTH, 1);
    chk("bp_issued_while_stalled", iss_cnt - base_iss, DEPTH);
    chk("bp_results_returned", dvld_cnt - base_dv, DEPTH);
    chk("bp_valid_while_stalled", bus.out_valid, 1);
    chk("bp_nothing_popped", pop_cnt - base_pop, 0);
    bus.out_ready = 1'b1;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 1000) begin
      @(negedge CLK);
      cyc++;
      if (bus.done) got = 1'b1;
    end
    repeat (2) @(negedge CLK);
    chk("bp_done_seen", got, 1);
    chk("bp_words", pop_cnt - base_pop, 100);
    chk("bp_issues", iss_cnt - base_iss, 100);
    chk("bp_sb_empty", exp_q.size(), 0);

    // Abort after 10 issues.
    @(posedge CLK); #1;
    base_iss = iss_cnt; base_dv = dvld_cnt; base_done = done_cnt;
    start_job(128'hc0ffee, 96'h9, 32'h300, 32'd50);
    n = 0; cyc = 0;
    while (n < 10 && cyc < 200) begin
      @(posedge CLK); #1;
      bus.start = 1'b0;
      cyc++;
      if (bus.aes_drdy) n++;
    end
    bus.abort = 1'b1;
    @(posedge CLK); #1;
    bus.abort = 1'b0;
    chk("ab_drdy_stopped", bus.aes_drdy, 0);
    chk("ab_valid_dropped", bus.out_valid, 0);
    chk("ab_busy_held", bus.busy, 1);
    flag_drdy = 1'b0; flag_valid = 1'b0; cyc = 0;
    while (bus.busy && cyc < 200) begin
      @(posedge CLK); #1;
      cyc++;
      flag_drdy  |= bus.aes_drdy;
      flag_valid |= bus.out_valid;
    end
    chk("ab_busy_fell", bus.busy, 0);
    chk("ab_issues", iss_cnt - base_iss, 10);
    chk("ab_all_results_back", dvld_cnt - base_dv, 10);
    chk("ab_no_drdy_in_flush", flag_drdy, 0);
    chk("ab_no_valid_in_flush", flag_valid, 0);
    repeat (2) @(posedge CLK);
    chk("ab_no_done", done_cnt - base_done, 0);
    exp_q.delete();
    run_job(tbl[5], "after_abort");

    // Reset in the middle of ISSUE.
    @(posedge CLK); #1;
    start_job(128'hbeef, 96'h1, 32'h400, 32'd40);
    n = 0; cyc = 0;
    while (n < 5 && cyc < 100) begin
      @(posedge CLK); #1;
      bus.start = 1'b0;
      cyc++;
      if (bus.aes_drdy) n++;
    end
    RSTn = 1'b0;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_drdy", bus.aes_drdy, 0);
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_kin", bus.aes_kin, '0);
    chk("mid_rst_din", bus.aes_din, '0);
    chk("mid_rst_data", bus.out_data, '0);
    @(posedge CLK); #1;
    RSTn = 1'b1;
    flag_valid = 1'b0; flag_drdy = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge CLK); #1;
      flag_valid |= bus.out_valid;
      flag_drdy  |= bus.busy;
    end
    chk("stale_dvld_no_valid", flag_valid, 0);
    chk("stale_dvld_no_busy", flag_drdy, 0);
    exp_q.delete();
    run_job(tbl[5], "after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
